// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM Avalon-MM master among three requesters:
//   port 0 = VGA pixel reader, port 1 = video-in frame writer, port 2 = edge detector.
// Round-robin grant with a bounded hold, combinational master mux from the grant
// register, and an owner-tag FIFO that routes each pipelined readdatavalid back
// to the port that issued the read.
// Build option: define VGA_PRIORITY_EN to let port 0 preempt any other owner and
// exempt it from the hold limit; ports 1 and 2 then rotate between themselves.

module sdram_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8,
    parameter int HOLD_MAX    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    // requester side
    input  logic [3*ADDR_W-1:0]           s_address,
    input  logic [2:0]                    s_read,
    input  logic [2:0]                    s_write,
    input  logic [3*DATA_W-1:0]           s_writedata,
    output logic [2:0]                    s_waitrequest,
    output logic [DATA_W-1:0]             s_readdata,
    output logic [2:0]                    s_readdatavalid,
    // master side
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_read,
    output logic                          m_write,
    output logic [DATA_W-1:0]             m_writedata,
    input  logic                          m_waitrequest,
    input  logic                          m_readdatavalid,
    input  logic [DATA_W-1:0]             m_readdata,
    // status
    output logic                          grant_valid,
    output logic [1:0]                    grant_owner,
    output logic [$clog2(MAX_PENDING):0]  pending_count,
    output logic                          err_orphan
);

    localparam int              PW        = $clog2(MAX_PENDING);
    localparam int              HW        = $clog2(HOLD_MAX + 1);
    localparam logic [PW:0]     FULL_CNT  = (PW+1)'(MAX_PENDING);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_MAX - 1);

    // grant register
    logic               r_grant_valid;
    logic [1:0]         r_owner;
    logic [1:0]         r_last_owner;
    logic [HW-1:0]      r_hold_cnt;
    logic               w_grant_valid_n;
    logic [1:0]         w_owner_n;
    logic [1:0]         w_last_owner_n;
    logic [HW-1:0]      w_hold_cnt_n;

    // tag FIFO
    logic [1:0]         r_tags [MAX_PENDING];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [PW:0]        r_count;
    logic               r_err_orphan;

    // combinational helpers
    logic [2:0]         w_req;
    logic [2:0]         w_own_sel;
    logic [ADDR_W-1:0]  w_own_addr;
    logic [DATA_W-1:0]  w_own_wdata;
    logic               w_own_rd;
    logic               w_own_wr;
    logic               w_own_req;
    logic               w_others;
    logic               w_fifo_full;
    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic               w_hold_rel;
    logic               w_release;
    logic               w_rr_any;
    logic [1:0]         w_rr_pick;
    logic [1:0]         w_pick;
    logic [1:0]         w_head;

    // A port requests on either strobe; write wins when both are high.
    assign w_req = s_read | s_write;

    // Decode the current owner and fetch its address / write data.
    always_comb begin
        w_own_sel   = 3'b000;
        w_own_addr  = '0;
        w_own_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_owner == 2'(i)) begin
                w_own_sel[i] = 1'b1;
                w_own_addr   = s_address[i*ADDR_W +: ADDR_W];
                w_own_wdata  = s_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_own_wr  = |(w_own_sel & s_write);
    assign w_own_rd  = |(w_own_sel & s_read & ~s_write);
    assign w_own_req = |(w_own_sel & w_req);
    assign w_others  = |(~w_own_sel & w_req);

    // A return arriving this cycle frees a slot, so a full FIFO can still accept.
    assign w_fifo_full = (r_count == FULL_CNT) & ~m_readdatavalid;

    // Master request mux.
    assign m_address   = w_own_addr;
    assign m_writedata = w_own_wdata;
    assign m_write     = r_grant_valid & w_own_wr;
    assign m_read      = r_grant_valid & w_own_rd & ~w_fifo_full;

    assign w_xfer = (m_read | m_write) & ~m_waitrequest;
    assign w_push = m_read & ~m_waitrequest;
    assign w_pop  = m_readdatavalid & (r_count != '0);

    // Per-port stall: only the owner sees the master's waitrequest.
    always_comb begin
        s_waitrequest = 3'b111;
        for (int i = 0; i < 3; i++) begin
            if (r_grant_valid && w_own_sel[i])
                s_waitrequest[i] = m_waitrequest | (w_own_rd & w_fifo_full);
        end
    end

    // Round-robin scan last_owner+1, +2, +3; descending loop leaves the first hit.
    always_comb begin
        w_rr_any  = |w_req;
        w_rr_pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (w_req[(int'(r_last_owner) + k) % 3])
                w_rr_pick = 2'((int'(r_last_owner) + k) % 3);
        end
    end

`ifdef VGA_PRIORITY_EN
    // Port 0 always wins a decision and bumps any other owner at the next edge;
    // it is never hold-released.
    assign w_pick     = w_req[0] ? 2'd0 : w_rr_pick;
    assign w_hold_rel = w_xfer & (r_hold_cnt == HOLD_LAST) & w_others & (r_owner != 2'd0);
    assign w_release  = r_grant_valid &
                        (~w_own_req | w_hold_rel | (w_req[0] & (r_owner != 2'd0)));
`else
    assign w_pick     = w_rr_pick;
    assign w_hold_rel = w_xfer & (r_hold_cnt == HOLD_LAST) & w_others;
    assign w_release  = r_grant_valid & (~w_own_req | w_hold_rel);
`endif

    // Next grant: re-arbitrate on release or when idle, otherwise count transfers.
    always_comb begin
        w_grant_valid_n = r_grant_valid;
        w_owner_n       = r_owner;
        w_last_owner_n  = r_last_owner;
        w_hold_cnt_n    = r_hold_cnt;
        if (!r_grant_valid || w_release) begin
            w_hold_cnt_n = '0;
            if (w_rr_any) begin
                w_grant_valid_n = 1'b1;
                w_owner_n       = w_pick;
                w_last_owner_n  = w_pick;
            end else begin
                w_grant_valid_n = 1'b0;
            end
        end else if (w_xfer && (r_hold_cnt != HOLD_LAST)) begin
            // saturates so a late-arriving waiter is served on the next transfer
            w_hold_cnt_n = r_hold_cnt + 1'b1;
        end
    end

    // Grant register; last_owner=2 out of reset so port 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_valid <= 1'b0;
            r_owner       <= 2'd0;
            r_last_owner  <= 2'd2;
            r_hold_cnt    <= '0;
        end else begin
            r_grant_valid <= w_grant_valid_n;
            r_owner       <= w_owner_n;
            r_last_owner  <= w_last_owner_n;
            r_hold_cnt    <= w_hold_cnt_n;
        end
    end

    // Tag storage: owner id of each accepted read, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) r_tags[r_wptr] <= r_owner;
    end

    // Tag FIFO pointers, occupancy and sticky orphan-return flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (m_readdatavalid && (r_count == '0)) r_err_orphan <= 1'b1;
        end
    end

    assign w_head = r_tags[r_rptr];

    // Route read data to the port at the FIFO head in the same cycle.
    always_comb begin
        s_readdatavalid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (w_pop && (w_head == 2'(i))) s_readdatavalid[i] = 1'b1;
        end
    end

    assign s_readdata    = m_readdata;
    assign grant_valid   = r_grant_valid;
    assign grant_owner   = r_owner;
    assign pending_count = r_count;
    assign err_orphan    = r_err_orphan;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: scoreboard bench for sdram_port_arbiter.
// Expected read returns (port, data) are queued when reads are issued and
// compared when s_readdatavalid fires. A small slave model returns each
// accepted read LAT cycles later with data = low 16 address bits.

module tb_sdram_port_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] s_address;
    logic [2:0]  s_read, s_write;
    logic [47:0] s_writedata;
    logic [2:0]  s_waitrequest, s_readdatavalid;
    logic [15:0] s_readdata;
    logic [31:0] m_address;
    logic        m_read, m_write;
    logic [15:0] m_writedata;
    logic        m_waitrequest, m_readdatavalid;
    logic [15:0] m_readdata;
    logic        grant_valid;
    logic [1:0]  grant_owner;
    logic [3:0]  pending_count;
    logic        err_orphan;

    typedef struct { int port; logic [15:0] data; } exp_t;
    typedef struct { int due;  logic [15:0] data; } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;
    bit   resp_en = 1'b1;
    bit   acc_now = 1'b0;

    sdram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
        .grant_valid(grant_valid), .grant_owner(grant_owner),
        .pending_count(pending_count), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    task automatic push_exp(input int p, input logic [15:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Step past the active edge, then update the slave's return channel.
    task automatic advance();
        @(posedge clk);
        #1;
        cyc_no++;
        m_readdatavalid = 1'b0;
        if (resp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc_no) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
    endtask

    // Manual single return (slave model disabled).
    task automatic pulse_return();
        rsp_t r;
        if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            m_readdatavalid = 1'b1;
            m_readdata      = r.data;
        end
    endtask

    // Mid-cycle sample: score returns, record accepted reads for the slave.
    task automatic sample();
        exp_t e;
        rsp_t r;
        @(negedge clk);
        if (m_readdatavalid) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdv_port", {29'd0, s_readdatavalid}, 32'(3'b001 << e.port));
                chk("rdv_data", {16'd0, s_readdata}, {16'd0, e.data});
            end else begin
                chk("rdv_orphan", {29'd0, s_readdatavalid}, 32'd0);
            end
        end
        acc_now = m_read && !m_waitrequest;
        if (acc_now) begin
            r.due  = cyc_no + LAT;
            r.data = m_address[15:0];
            rsp_q.push_back(r);
        end
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            advance();
            if (!resp_en) pulse_return();
            sample();
            guard++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Port p issues n reads with addresses base, base+1, ...
    task automatic issue(input int p, input int n, input logic [15:0] base);
        int cnt = 0;
        int guard = 0;
        for (int j = 0; j < n; j++) push_exp(p, base + 16'(j));
        advance();
        s_address[p*32 +: 32] = {16'd0, base};
        s_read[p] = 1'b1;
        sample();
        while (guard < 50) begin
            advance();
            s_address[p*32 +: 32] = {16'd0, base} + 32'(cnt);
            sample();
            guard++;
            if (acc_now) cnt++;
            if (cnt == n) break;
        end
        advance();
        s_read[p] = 1'b0;
        sample();
        chk("issue_cnt", cnt, n);
    endtask

    initial begin
        int sw;
        reset = 1'b1;
        s_address = '0; s_read = '0; s_write = '0; s_writedata = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;

        // ---- reset state
        advance(); sample();
        chk("rst_gv",    grant_valid, 0);
        chk("rst_owner", grant_owner, 0);
        chk("rst_wait",  s_waitrequest, 3'b111);
        chk("rst_rdv",   s_readdatavalid, 0);
        chk("rst_mrd",   m_read, 0);
        chk("rst_mwr",   m_write, 0);
        chk("rst_pend",  pending_count, 0);
        chk("rst_err",   err_orphan, 0);
        advance(); reset = 1'b0; sample();
        chk("rst_rel_wait", s_waitrequest, 3'b111);

        // ---- round robin across all three ports, 16 reads per grant
        for (int j = 0; j < 48; j++) push_exp((j / 16) % 3, 16'h1000 * 16'((j / 16) % 3 + 1));
        advance();
        s_address = {32'h3000, 32'h2000, 32'h1000};
        s_read = 3'b111;
        sample();
        chk("rot_idle_mrd", m_read, 0);
        for (int j = 0; j < 48; j++) begin
            advance(); sample();
            chk("rot_owner", grant_owner, (j / 16) % 3);
            chk("rot_mrd", m_read, 1);
        end
        advance(); s_read = 3'b000; sample();
        chk("rot_stop_mrd", m_read, 0);
        drain("rot_drain");

        // ---- posted write from port 1 with master stall of 3 cycles
        advance();
        s_address[32 +: 32] = 32'h0000_0100;
        s_writedata[16 +: 16] = 16'h1234;
        s_write[1] = 1'b1;
        m_waitrequest = 1'b1;
        sample();
        chk("wr_lat0_mwr", m_write, 0);
        for (int k = 0; k < 3; k++) begin
            advance(); sample();
            chk("wr_mwr",   m_write, 1);
            chk("wr_addr",  m_address, 32'h0000_0100);
            chk("wr_data",  m_writedata, 16'h1234);
            chk("wr_stall", s_waitrequest, 3'b111);
        end
        advance(); m_waitrequest = 1'b0; sample();
        chk("wr_go_wait", s_waitrequest, 3'b101);
        chk("wr_go_mwr",  m_write, 1);
        advance(); s_write[1] = 1'b0; sample();
        chk("wr_done_mwr", m_write, 0);
        chk("wr_no_tag",   pending_count, 0);

        // ---- interleaved reads: port 0 x3 then port 2 x2, latency 4
        issue(0, 3, 16'h0300);
        issue(2, 2, 16'h0320);
        drain("ilv_drain");

        // ---- tag FIFO full, then a single return frees a slot in the same cycle
        resp_en = 1'b0;
        begin
            int cnt = 0;
            int guard = 0;
            for (int j = 0; j < 9; j++) push_exp(0, 16'h0400 + 16'(j));
            advance();
            s_address[0 +: 32] = 32'h0400;
            s_read[0] = 1'b1;
            sample();
            while (cnt < 8 && guard < 30) begin
                advance();
                s_address[0 +: 32] = 32'h0400 + 32'(cnt);
                sample();
                guard++;
                if (acc_now) cnt++;
            end
            chk("full_cnt", cnt, 8);
            advance();
            s_address[0 +: 32] = 32'h0408;
            sample();
            chk("full_pend", pending_count, 8);
            chk("full_mrd",  m_read, 0);
            chk("full_wait", s_waitrequest[0], 1);
            advance(); pulse_return(); sample();
            chk("full_pass_mrd",  m_read, 1);
            chk("full_pass_wait", s_waitrequest[0], 0);
            advance(); s_read[0] = 1'b0; sample();
            chk("full_pend_same", pending_count, 8);
        end
        drain("full_drain");
        resp_en = 1'b1;

        // ---- port 0 arrives while port 2 bursts
`ifdef VGA_PRIORITY_EN
        sw = 5;
`else
        sw = 17;
`endif
        for (int j = 0; j < sw - 1; j++) push_exp(2, 16'h0700);
        push_exp(0, 16'h0500);
        push_exp(0, 16'h0500);
        advance();
        s_address[64 +: 32] = 32'h0700;
        s_address[0 +: 32]  = 32'h0500;
        s_read[2] = 1'b1;
        sample();
        chk("pri_idle_gv", grant_valid, 0);
        for (int r = 1; r <= sw + 2; r++) begin
            advance();
            if (r == 4)      s_read[0] = 1'b1;
            if (r == sw)     s_read[2] = 1'b0;
            if (r == sw + 2) s_read[0] = 1'b0;
            sample();
            if (r < sw)                 chk("pri_own2", grant_owner, 2);
            if (r == sw || r == sw + 1) chk("pri_own0", grant_owner, 0);
        end
        drain("pri_drain");

        // ---- reset mid-operation drops tags; late data is an orphan
        resp_en = 1'b0;
        advance();
        s_address[64 +: 32] = 32'h0900;
        s_read[2] = 1'b1;
        sample();
        advance(); sample();
        advance(); sample();
        advance(); s_read[2] = 1'b0; sample();
        chk("orph_pend_pre", pending_count, 2);
        advance(); reset = 1'b1; sample();
        rsp_q.delete();
        chk("orph_rst_pend", pending_count, 0);
        chk("orph_rst_gv",   grant_valid, 0);
        advance(); reset = 1'b0; sample();
        chk("orph_err_clr", err_orphan, 0);
        advance();
        m_readdatavalid = 1'b1;
        m_readdata = 16'hDEAD;
        sample();
        chk("orph_err_now", err_orphan, 0);
        advance(); sample();
        chk("orph_err_set", err_orphan, 1);
        advance(); sample();
        advance(); sample();
        chk("orph_err_sticky", err_orphan, 1);
        chk("orph_rdv_none", s_readdatavalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Three-requester arbiter that shares the single SDRAM Avalon-MM master of the Computer_System among the VGA pixel reader (port 0), the video-in frame writer (port 1) and the edge-detector engine (port 2). It grants one owner at a time using round-robin with a bounded hold, muxes the owner's address and data onto the master, and tracks outstanding pipelined reads so that each readdatavalid is routed back to the requester that issued the read.

## Interface
- ADDR_W, 32, address width of every port
- DATA_W, 16, data width (SDRAM word)
- MAX_PENDING, 8, outstanding-read tag FIFO depth; power of 2, ≥2
- HOLD_MAX, 16, maximum consecutive accepted transfers per grant while another requester waits
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  3*ADDR_W  requester addresses, port i at [i*ADDR_W +: ADDR_W]
- s_read / s_write  in  3  per-port read / write strobes
- s_writedata  in  3*DATA_W  per-port write data
- s_waitrequest  out  3  per-port stall
- s_readdata  out  DATA_W  read data, broadcast to all ports
- s_readdatavalid  out  3  per-port read-data qualifier
- m_address  out  ADDR_W; m_read, m_write  out  1; m_writedata  out  DATA_W  master request
- m_waitrequest, m_readdatavalid  in  1; m_readdata  in  DATA_W  master response
- grant_valid  out  1; grant_owner  out  2  current grant (status)
- pending_count  out  log2(MAX_PENDING)+1  outstanding reads
- err_orphan  out  1  sticky: readdatavalid arrived with no outstanding read

## Operation
- Grant register {grant_valid, grant_owner, last_owner, hold_cnt}; all updates on the clk edge.
- Request of port i: req[i] = s_read[i] | s_write[i]. If both strobes are asserted, treat as write; the read is ignored.
- Arbitration (grant_valid=0, or release): next owner = first requesting port scanning last_owner+1, +2, +3 (mod 3). No requests → grant_valid=0.
- Release at an edge when: owner's req is low; or a transfer is accepted, hold_cnt = HOLD_MAX-1, and another port requests. The new owner is chosen at that same edge (no idle cycle). hold_cnt clears on every new grant and increments per accepted transfer.
- Master mux (combinational from the grant register): m_address/m_writedata from owner; m_write = grant_valid & s_write[owner]; m_read = grant_valid & s_read[owner] & ~s_write[owner] & ~fifo_full.
- s_waitrequest[i] = 1 unless grant_valid & owner==i; otherwise equals m_waitrequest, or 1 when the owner's read is blocked by fifo_full.
- Accepted read (m_read & ~m_waitrequest) pushes owner id into the tag FIFO. m_readdatavalid pops; s_readdatavalid[head]=1 for that cycle, s_readdata = m_readdata. Push and pop in the same cycle are both performed; count unchanged.
- m_readdatavalid with empty FIFO: no s_readdatavalid; err_orphan sets and is cleared only by reset.
- Writes are posted and produce no tag.

## Timing
- Reset values: grant_valid=0, grant_owner=0, last_owner=2 (port 0 wins first), hold_cnt=0, FIFO empty, pending_count=0, err_orphan=0, s_waitrequest=3'b111, s_readdatavalid=0, m_read=m_write=0.
- Request to master strobe: 1 cycle when idle; 0 cycles for a port that is already the owner.
- Read return: s_readdatavalid in the same cycle as m_readdatavalid (combinational route from FIFO head).
- Reset mid-operation drops all tags; late read data after reset sets err_orphan.

## Configuration
- VGA_PRIORITY_EN defined: port 0 preempts at the next edge whenever req[0]=1 and owner≠0, irrespective of hold_cnt. Port 0 is never released for HOLD_MAX while other ports wait, only when req[0] drops. Ports 1 and 2 round-robin between themselves.
- Undefined: pure round-robin across all three ports as above.

## Test plan
- Reset, then ports 0,1,2 all read, m_waitrequest=0 → owners 0,1,2 in rotation. HOLD_MAX=16 → each port gets 16 accepted reads per grant.
- Port 1 writes 0x1234 to 0x00000100 while port 0 is idle → m_write at cycle 1 after request; s_waitrequest[1] mirrors m_waitrequest held high for 3 cycles.
- Interleaved reads: port 0 issues 3, then port 2 issues 2, with latency 4 → s_readdatavalid pattern 0,0,0,2,2 with matching data.
- MAX_PENDING=8 reads outstanding with no return → m_read=0, s_waitrequest=1. A single readdatavalid → next read accepted the same cycle.
- m_readdatavalid pulse after reset with empty FIFO → err_orphan=1, no s_readdatavalid.
- With VGA_PRIORITY_EN, port 2 bursting and port 0 requesting at cycle N → grant_owner=0 at N+1. Without the macro → the switch waits for port 2's release or HOLD_MAX.
